// File: rtl/eth_pcs_tx_scrambler.sv
// 64b/66b TX scrambler G(x)=1+x^39+x^58 applied word-by-word to the block payload.
// The sync header and word index ride alongside with the same one-cycle latency.

package eth_pcs_params;
    parameter int W_DATA          = 32;
    parameter int W_SYNC          = 2;
    parameter int N_TRANS_PER_BLK = 2;
    parameter int W_TRANS_PER_BLK = 1;
endpackage

module eth_pcs_tx_scrambler
    import eth_pcs_params::*;
#(
    parameter logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clk_en,
    input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
    input  logic [W_SYNC-1:0]          i_sync_data,
    input  logic [W_DATA-1:0]          i_pld_data,
    input  logic                       i_scr_bypass,
    output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt,
    output logic [W_SYNC-1:0]          o_sync_data,
    output logic [W_DATA-1:0]          o_pld_data
);

    logic [57:0]       scr_state;
    logic [57:0]       scr_next;
    logic [57:0]       scr_walk;
    logic [W_DATA-1:0] scr_word;
    logic              bypass_q;
    logic              blk_start;
    logic              bypass_eff;

    assign blk_start  = (i_trans_cnt == '0);
    // The first word of a block sees the live bypass request; later words use the latched one.
    assign bypass_eff = blk_start ? i_scr_bypass : bypass_q;

    // Unrolled serial scrambler, LSB first; s[0] holds the newest scrambled bit.
    always_comb begin
        scr_walk = scr_state;
        scr_word = '0;
        for (int k = 0; k < W_DATA; k++) begin
            scr_word[k] = i_pld_data[k] ^ scr_walk[38] ^ scr_walk[57];
            scr_walk    = {scr_walk[56:0], scr_word[k]};
        end
        scr_next = scr_walk;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scr_state   <= SCR_SEED;
            bypass_q    <= 1'b0;
            o_pld_data  <= '0;
            o_sync_data <= '0;
            o_trans_cnt <= '0;
        end else if (i_clk_en) begin
            if (blk_start) begin
                bypass_q <= i_scr_bypass;
            end
            if (!bypass_eff) begin
                scr_state <= scr_next;
            end
            o_pld_data  <= bypass_eff ? i_pld_data : scr_word;
            o_sync_data <= i_sync_data;
            o_trans_cnt <= i_trans_cnt;
        end
    end

endmodule

// File: tb/tb_eth_pcs_tx_scrambler.sv
// Directed table vectors plus reset, clock-enable, bypass and descrambler checks
// for eth_pcs_tx_scrambler.

module tb_eth_pcs_tx_scrambler;
    import eth_pcs_params::*;

    logic                       i_clk = 1'b0;
    logic                       i_reset_n;
    logic                       i_clk_en;
    logic [W_TRANS_PER_BLK-1:0] i_trans_cnt;
    logic [W_SYNC-1:0]          i_sync_data;
    logic [W_DATA-1:0]          i_pld_data;
    logic                       i_scr_bypass;
    logic [W_TRANS_PER_BLK-1:0] o_trans_cnt;
    logic [W_SYNC-1:0]          o_sync_data;
    logic [W_DATA-1:0]          o_pld_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic                       rst;
        logic                       en;
        logic [W_TRANS_PER_BLK-1:0] cnt;
        logic [W_SYNC-1:0]          sync;
        logic [W_DATA-1:0]          pld;
        logic                       byp;
        logic [W_DATA-1:0]          exp_pld;
        logic [W_SYNC-1:0]          exp_sync;
        logic [W_TRANS_PER_BLK-1:0] exp_cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [57:0] dscr_state;

    eth_pcs_tx_scrambler dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clk_en     (i_clk_en),
        .i_trans_cnt  (i_trans_cnt),
        .i_sync_data  (i_sync_data),
        .i_pld_data   (i_pld_data),
        .i_scr_bypass (i_scr_bypass),
        .o_trans_cnt  (o_trans_cnt),
        .o_sync_data  (o_sync_data),
        .o_pld_data   (o_pld_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic [31:0] e_pld, input logic [1:0] e_sync,
                            input logic e_cnt);
        checkOutput({name, ".pld"}, o_pld_data, e_pld);
        checkOutput({name, ".sync"}, {30'd0, o_sync_data}, {30'd0, e_sync});
        checkOutput({name, ".cnt"}, {31'd0, o_trans_cnt}, {31'd0, e_cnt});
    endtask

    task automatic applyStimulus(input logic en, input logic cnt, input logic [1:0] sync,
                                 input logic [31:0] pld, input logic byp);
        i_clk_en     = en;
        i_trans_cnt  = cnt;
        i_sync_data  = sync;
        i_pld_data   = pld;
        i_scr_bypass = byp;
        @(posedge i_clk);
        #1;
    endtask

    // Called just after a rising edge; the reset pulse sits entirely between edges.
    task automatic doReset();
        i_reset_n = 1'b0;
        #3;
        i_reset_n = 1'b1;
        #1;
    endtask

    task automatic addVec(input logic rst, input logic en, input logic cnt, input logic [1:0] sync,
                          input logic [31:0] pld, input logic byp, input logic [31:0] e_pld,
                          input logic [1:0] e_sync, input logic e_cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.cnt = cnt; v.sync = sync; v.pld = pld; v.byp = byp;
        v.exp_pld = e_pld; v.exp_sync = e_sync; v.exp_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // Reference descrambler, shifting in the received (scrambled) bits.
    task automatic descramble(input logic [31:0] d, output logic [31:0] q);
        for (int k = 0; k < 32; k++) begin
            q[k]       = d[k] ^ dscr_state[38] ^ dscr_state[57];
            dscr_state = {dscr_state[56:0], d[k]};
        end
    endtask

    initial begin
        logic [31:0] rnd_pld;
        logic [31:0] rx;
        logic [1:0]  rnd_sync;

        i_reset_n    = 1'b0;
        i_clk_en     = 1'b1;
        i_trans_cnt  = 1'b1;
        i_sync_data  = 2'b11;
        i_pld_data   = 32'hFFFF_FFFF;
        i_scr_bypass = 1'b0;

        // Zero-payload stream from the all-ones seed: 0, 03FFFF80, FFFFC000, FFEFFFFF.
        addVec(1, 1, 0, 2'b10, 32'h0, 0, 32'h0000_0000, 2'b10, 0);
        addVec(0, 1, 1, 2'b10, 32'h0, 0, 32'h03FF_FF80, 2'b10, 1);
        addVec(0, 1, 0, 2'b01, 32'h0, 0, 32'hFFFF_C000, 2'b01, 0);
        addVec(0, 1, 1, 2'b01, 32'h0, 0, 32'hFFEF_FFFF, 2'b01, 1);
        // Clock enable low: outputs, state and bypass latch all hold.
        addVec(1, 1, 0, 2'b10, 32'h0,         0, 32'h0000_0000, 2'b10, 0);
        addVec(0, 0, 1, 2'b01, 32'hDEAD_BEEF, 1, 32'h0000_0000, 2'b10, 0);
        addVec(0, 0, 0, 2'b11, 32'hFFFF_FFFF, 1, 32'h0000_0000, 2'b10, 0);
        addVec(0, 1, 1, 2'b10, 32'h0,         0, 32'h03FF_FF80, 2'b10, 1);
        // Bypass requested mid-block takes effect on the next block; state frozen meanwhile.
        addVec(1, 1, 0, 2'b10, 32'h0,         0, 32'h0000_0000, 2'b10, 0);
        addVec(0, 1, 1, 2'b10, 32'h0,         1, 32'h03FF_FF80, 2'b10, 1);
        addVec(0, 1, 0, 2'b01, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 2'b01, 0);
        addVec(0, 1, 1, 2'b01, 32'h1234_5678, 0, 32'h1234_5678, 2'b01, 1);
        addVec(0, 1, 0, 2'b10, 32'h0,         0, 32'hFFFF_C000, 2'b10, 0);
        addVec(0, 1, 1, 2'b10, 32'h0,         0, 32'hFFEF_FFFF, 2'b10, 1);

        // Reset holds outputs at zero even with enable and clock running.
        #2;
        checkAll("reset_idle", 32'h0, 2'b00, 1'b0);
        @(posedge i_clk);
        #1;
        checkAll("reset_clocked", 32'h0, 2'b00, 1'b0);
        i_reset_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].en, vecs[i].cnt, vecs[i].sync, vecs[i].pld, vecs[i].byp);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_pld, vecs[i].exp_sync, vecs[i].exp_cnt);
        end

        // Asynchronous reset in the middle of a block.
        doReset();
        applyStimulus(1, 0, 2'b10, 32'h0, 0);
        applyStimulus(1, 1, 2'b11, 32'h0, 0);
        checkAll("prerst_w1", 32'h03FF_FF80, 2'b11, 1'b1);
        applyStimulus(1, 0, 2'b01, 32'h0, 0);
        checkAll("prerst_w2", 32'hFFFF_C000, 2'b01, 1'b0);
        i_trans_cnt = 1'b1;
        #3;
        i_reset_n = 1'b0;
        #1;
        checkAll("async_rst", 32'h0, 2'b00, 1'b0);
        i_trans_cnt = 1'b0;
        i_sync_data = 2'b10;
        #2;
        i_reset_n = 1'b1;
        applyStimulus(1, 0, 2'b10, 32'h0, 0);
        checkAll("postrst_w0", 32'h0, 2'b10, 1'b0);
        applyStimulus(1, 1, 2'b10, 32'h0, 0);
        checkAll("postrst_w1", 32'h03FF_FF80, 2'b10, 1'b1);

        // Random blocks through a self-synchronizing descrambler starting from zero state.
        doReset();
        dscr_state = '0;
        for (int w = 0; w < 2000; w++) begin
            rnd_pld  = $urandom;
            rnd_sync = 2'($urandom_range(1, 2));
            applyStimulus(1, w[0], rnd_sync, rnd_pld, 0);
            descramble(o_pld_data, rx);
            if (w >= 2) begin
                checkOutput($sformatf("rand_w%0d", w), rx, rnd_pld);
            end
            checkOutput($sformatf("rand_sync%0d", w), {30'd0, o_sync_data}, {30'd0, rnd_sync});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
